// File: rtl/usb_rx_gen_pkg.sv
// Shared types and constants for the USB bit-level receiver.
package usb_rx_gen_pkg;

  // Error classes reported on err_code
  typedef enum logic [1:0] {
    RX_ERR_NONE  = 2'd0,
    RX_ERR_STUFF = 2'd1,
    RX_ERR_ALIGN = 2'd2,
    RX_ERR_OVFL  = 2'd3
  } rx_err_e;

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DATA      = 3'd1,
    ST_STRIP_EOP = 3'd2,
    ST_ERROR     = 3'd3,
    ST_ABORT     = 3'd4
  } rx_state_e;

  // Minimum decoded zeros closing SYNC for full/low speed and high speed
  localparam int SYNC_ZEROS_FS = 6;
  localparam int SYNC_ZEROS_HS = 12;

  // After this many consecutive ones the transmitter inserts a zero
  localparam int STUFF_RUN = 6;

  // Idle line level (J) as seen on d_i
  localparam logic LINE_J = 1'b0;

endpackage

// File: rtl/usb_nrzi_unstuff.sv
// NRZI decoder and bit unstuffer: turns raw line levels into data bits,
// drops stuffed zeros and flags a seventh consecutive one while running.
module usb_nrzi_unstuff
  import usb_rx_gen_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clk_en,
  input  logic i_d,
  input  logic i_run,
  output logic o_bit,
  output logic o_bit_en,
  output logic o_stuff_err
);

  logic       r_prev_line;
  logic [2:0] r_ones;
  logic       w_dec;
  logic       w_at_limit;

  // A bit is one when the line did not change since the previous bit
  assign w_dec       = (i_d == r_prev_line);
  assign w_at_limit  = i_run && (r_ones == 3'(STUFF_RUN));
  assign o_bit       = w_dec;
  assign o_bit_en    = i_clk_en && !(w_at_limit && !w_dec);
  assign o_stuff_err = i_clk_en && w_at_limit && w_dec;

  // Track the previous line level on every bit strobe
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_prev_line <= LINE_J;
    else if (i_clk_en) r_prev_line <= i_d;
  end

  // Count consecutive decoded ones only while the packet body is running
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ones <= '0;
    end else if (!i_run) begin
      r_ones <= '0;
    end else if (i_clk_en) begin
      if (!w_dec) r_ones <= '0;
      else if (!w_at_limit) r_ones <= r_ones + 3'd1;
    end
  end

endmodule

// File: rtl/usb_rx_gen.sv
// USB bit-level receiver: SYNC hunt, byte assembly, per-packet byte count
// and classified sticky error reporting with automatic recovery via ABORT.
module usb_rx_gen
  import usb_rx_gen_pkg::*;
#(
  parameter int SYNC_MIN_ZEROS  = SYNC_ZEROS_FS,
  parameter int MAX_BYTES       = 1027,
  parameter int CNT_W           = 11,
  parameter int ABORT_IDLE_BITS = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_en,
  input  logic             d_i,
  input  logic             eop,
  output logic [7:0]       data,
  output logic             valid,
  output logic             active,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             error,
  output logic [1:0]       err_code
);

  localparam int ZW = $clog2(SYNC_MIN_ZEROS + 1);
  localparam int AW = $clog2(ABORT_IDLE_BITS + 1);

  rx_state_e        r_state;
  rx_state_e        w_next;
  rx_err_e          w_err_cause;
  rx_err_e          r_err_code;
  logic [ZW-1:0]    r_zeros;
  logic [AW-1:0]    r_idle_ones;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_valid;
  logic [CNT_W-1:0] r_byte_cnt;
  logic             w_active;
  logic             w_error;

  logic w_bit;
  logic w_bit_en;
  logic w_stuff_err;
  logic w_run;
  logic w_sync_done;
  logic w_data_bit;
  logic w_byte_done;
  logic w_ovfl;
  logic w_deliver;
  logic w_abort_done;

  usb_nrzi_unstuff u_nrzi (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_clk_en    (clk_en),
    .i_d         (d_i),
    .i_run       (w_run),
    .o_bit       (w_bit),
    .o_bit_en    (w_bit_en),
    .o_stuff_err (w_stuff_err)
  );

  // eop wins over any bit arriving in the same cycle, so a byte that
  // completes alongside eop never counts as a data bit
  assign w_run        = (r_state == ST_DATA);
  assign w_sync_done  = (r_state == ST_IDLE) && w_bit_en && w_bit &&
                        (r_zeros >= ZW'(SYNC_MIN_ZEROS));
  assign w_data_bit   = (r_state == ST_DATA) && !eop && w_bit_en && !w_stuff_err;
  assign w_byte_done  = w_data_bit && (r_bit_cnt == 3'd7);
  assign w_ovfl       = w_byte_done && (r_byte_cnt == CNT_W'(MAX_BYTES));
  assign w_deliver    = w_byte_done && !w_ovfl;
  assign w_abort_done = (r_state == ST_ABORT) && w_bit_en && w_bit &&
                        (r_idle_ones == AW'(ABORT_IDLE_BITS - 1));

  assign data     = r_data;
  assign valid    = r_valid;
  assign active   = w_active;
  assign byte_cnt = r_byte_cnt;
  assign error    = w_error;
  assign err_code = r_err_code;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  end

  // Next-state logic, error classification and state-decoded outputs
  always_comb begin
    w_next      = r_state;
    w_err_cause = RX_ERR_NONE;
    w_active    = 1'b0;
    w_error     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_sync_done) w_next = ST_DATA;
      end
      ST_DATA: begin
        w_active = 1'b1;
        if (eop) begin
          if (r_bit_cnt == 3'd0) begin
            w_next = ST_STRIP_EOP;
          end else begin
            w_next      = ST_ERROR;
            w_err_cause = RX_ERR_ALIGN;
          end
        end else if (w_stuff_err) begin
          w_next      = ST_ERROR;
          w_err_cause = RX_ERR_STUFF;
        end else if (w_ovfl) begin
          w_next      = ST_ERROR;
          w_err_cause = RX_ERR_OVFL;
        end
      end
      ST_STRIP_EOP: begin
        w_active = 1'b1;
        w_next   = ST_IDLE;
      end
      ST_ERROR: begin
        w_error = 1'b1;
        w_next  = ST_ABORT;
      end
      ST_ABORT: begin
        if (w_abort_done) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // SYNC hunt: saturating count of decoded zeros, only meaningful in IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_zeros <= '0;
    end else if ((r_state != ST_IDLE) || w_sync_done) begin
      r_zeros <= '0;
    end else if (w_bit_en) begin
      if (w_bit) r_zeros <= '0;
      else if (r_zeros < ZW'(SYNC_MIN_ZEROS)) r_zeros <= r_zeros + ZW'(1);
    end
  end

  // Consecutive J bits seen while waiting in ABORT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idle_ones <= '0;
    end else if (r_state != ST_ABORT) begin
      r_idle_ones <= '0;
    end else if (w_bit_en) begin
      if (w_bit) r_idle_ones <= r_idle_ones + AW'(1);
      else r_idle_ones <= '0;
    end
  end

  // Byte assembly: bits arrive LSB first and enter at the MSB
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_sync_done) begin
      r_bit_cnt <= '0;
    end else if (w_data_bit) begin
      r_shift   <= {w_bit, r_shift[7:1]};
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  // Deliver completed bytes one clock after their last bit and count them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_byte_cnt <= '0;
    end else begin
      r_valid <= w_deliver;
      if (w_deliver) begin
        r_data     <= {w_bit, r_shift[7:1]};
        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
      end else if (w_sync_done) begin
        r_byte_cnt <= '0;
      end
    end
  end

  // Sticky error class: cleared by a completed SYNC, loaded on entry to ERROR
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_code <= RX_ERR_NONE;
    end else if (w_sync_done) begin
      r_err_code <= RX_ERR_NONE;
    end else if ((r_state == ST_DATA) && (w_next == ST_ERROR)) begin
      r_err_code <= w_err_cause;
    end
  end

endmodule

// File: tb/tb_usb_rx_gen.sv
// Self-checking bench for usb_rx_gen. Three instances share one line:
// default full-speed, a 4-byte packet limit, and a high-speed SYNC hunt.
module tb_usb_rx_gen;
  import usb_rx_gen_pkg::*;

  logic clk = 1'b0;
  logic resetN, clkEn, dIn, eopIn;

  logic [7:0]  dataFs, dataOv, dataHs;
  logic        validFs, validOv, validHs;
  logic        activeFs, activeOv, activeHs;
  logic [10:0] cntFs, cntOv, cntHs;
  logic        errorFs, errorOv, errorHs;
  logic [1:0]  codeFs, codeOv, codeHs;

  int nChecks = 0;
  int nFails  = 0;

  logic       txLine;
  int         txOnes;
  logic [7:0] txBytes[$];

  logic [7:0] qFs[$], qOv[$], qHs[$];
  logic [1:0] eFs[$], eOv[$], eHs[$];
  int         actFs;

  usb_rx_gen dutFs (
    .clk(clk), .reset_n(resetN), .clk_en(clkEn), .d_i(dIn), .eop(eopIn),
    .data(dataFs), .valid(validFs), .active(activeFs), .byte_cnt(cntFs),
    .error(errorFs), .err_code(codeFs));

  usb_rx_gen #(.MAX_BYTES(4)) dutOv (
    .clk(clk), .reset_n(resetN), .clk_en(clkEn), .d_i(dIn), .eop(eopIn),
    .data(dataOv), .valid(validOv), .active(activeOv), .byte_cnt(cntOv),
    .error(errorOv), .err_code(codeOv));

  usb_rx_gen #(.SYNC_MIN_ZEROS(SYNC_ZEROS_HS)) dutHs (
    .clk(clk), .reset_n(resetN), .clk_en(clkEn), .d_i(dIn), .eop(eopIn),
    .data(dataHs), .valid(validHs), .active(activeHs), .byte_cnt(cntHs),
    .error(errorHs), .err_code(codeHs));

  // Free-running clock
  always #5 clk = ~clk;

  // Record delivered bytes, error pulses and active cycles on the falling edge
  always @(negedge clk) begin
    if (validFs) qFs.push_back(dataFs);
    if (errorFs) eFs.push_back(codeFs);
    if (activeFs) actFs++;
    if (validOv) qOv.push_back(dataOv);
    if (errorOv) eOv.push_back(codeOv);
    if (validHs) qHs.push_back(dataHs);
    if (errorHs) eHs.push_back(codeHs);
  end

  // Hard time limit so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected end of tests");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clearMon();
    qFs.delete(); qOv.delete(); qHs.delete();
    eFs.delete(); eOv.delete(); eHs.delete();
    actFs = 0;
  endtask

  task automatic applyStimulus(input logic en, input logic lvl, input logic e);
    @(posedge clk);
    #1;
    clkEn = en;
    dIn   = lvl;
    eopIn = e;
  endtask

  task automatic doReset();
    resetN = 1'b0; clkEn = 1'b0; dIn = LINE_J; eopIn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;
    txLine = LINE_J;
    txOnes = 0;
    @(posedge clk);
  endtask

  // One line symbol followed by one to three idle clocks
  task automatic driveBit(input logic lvl);
    applyStimulus(1'b1, lvl, 1'b0);
    repeat ($urandom_range(1, 3)) applyStimulus(1'b0, lvl, 1'b0);
  endtask

  // NRZI encode one decoded bit: zero toggles the line, one holds it
  task automatic txRaw(input logic b);
    if (!b) txLine = ~txLine;
    driveBit(txLine);
  endtask

  // Packet body bit with transmitter-side stuffing after six ones
  task automatic txData(input logic b);
    txRaw(b);
    if (b) txOnes++;
    else txOnes = 0;
    if (txOnes == STUFF_RUN) begin
      txRaw(1'b0);
      txOnes = 0;
    end
  endtask

  task automatic txSync(input int nz);
    repeat (nz) txRaw(1'b0);
    txRaw(1'b1);
    txOnes = 0;
  endtask

  task automatic txByte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) txData(v[i]);
  endtask

  task automatic txIdle(input int n);
    repeat (n) txRaw(1'b1);
  endtask

  // One-clock eop strobe; returns active on the eop clock and the two after
  task automatic sendEop(output logic a0, output logic a1, output logic a2);
    applyStimulus(1'b0, txLine, 1'b1);
    @(negedge clk) a0 = activeFs;
    applyStimulus(1'b0, txLine, 1'b0);
    @(negedge clk) a1 = activeFs;
    @(negedge clk) a2 = activeFs;
  endtask

  task automatic fillRandom(input int n);
    txBytes.delete();
    for (int i = 0; i < n; i++)
      txBytes.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
  endtask

  task automatic sendPacket(input int nz);
    logic a0, a1, a2;
    txSync(nz);
    foreach (txBytes[i]) txByte(txBytes[i]);
    sendEop(a0, a1, a2);
  endtask

  task automatic test_reset();
    doReset();
    nChecks++; if (dataFs !== 8'h00) begin nFails++; $display("[TB] FAIL reset_data: got %h, want 00", dataFs); end
    nChecks++; if (validFs !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid: got %b, want 0", validFs); end
    nChecks++; if (activeFs !== 1'b0) begin nFails++; $display("[TB] FAIL reset_active: got %b, want 0", activeFs); end
    nChecks++; if (cntFs !== 11'd0) begin nFails++; $display("[TB] FAIL reset_byte_cnt: got %0d, want 0", cntFs); end
    nChecks++; if (errorFs !== 1'b0) begin nFails++; $display("[TB] FAIL reset_error: got %b, want 0", errorFs); end
    nChecks++; if (codeFs !== RX_ERR_NONE) begin nFails++; $display("[TB] FAIL reset_err_code: got %0d, want 0", codeFs); end
  endtask

  task automatic test_basic();
    logic a0, a1, a2;
    logic [7:0] exp[3] = '{8'h69, 8'h12, 8'h34};
    logic [7:0] last;
    doReset();
    clearMon();
    txIdle(3);
    txSync(7);
    txByte(8'h69);
    txByte(8'h12);
    last = 8'h34;
    for (int i = 0; i < 7; i++) txData(last[i]);
    if (!last[7]) txLine = ~txLine;
    applyStimulus(1'b1, txLine, 1'b0);
    @(negedge clk);
    nChecks++; if (validFs !== 1'b0) begin nFails++; $display("[TB] FAIL basic_latency_early: valid %b, want 0", validFs); end
    applyStimulus(1'b0, txLine, 1'b0);
    @(negedge clk);
    nChecks++; if (validFs !== 1'b1 || dataFs !== 8'h34) begin nFails++; $display("[TB] FAIL basic_latency: valid %b data %h, want 1 34", validFs, dataFs); end
    nChecks++; if (cntFs !== 11'd3) begin nFails++; $display("[TB] FAIL basic_cnt_with_valid: got %0d, want 3", cntFs); end
    sendEop(a0, a1, a2);
    nChecks++; if ({a0, a1, a2} !== 3'b110) begin nFails++; $display("[TB] FAIL basic_active_eop: got %b, want 110", {a0, a1, a2}); end
    nChecks++; if (qFs.size() != 3) begin nFails++; $display("[TB] FAIL basic_valid_count: got %0d, want 3", qFs.size()); end
    else for (int i = 0; i < 3; i++) begin
      nChecks++; if (qFs[i] !== exp[i]) begin nFails++; $display("[TB] FAIL basic_data[%0d]: got %h, want %h", i, qFs[i], exp[i]); end
    end
    nChecks++; if (cntFs !== 11'd3) begin nFails++; $display("[TB] FAIL basic_byte_cnt: got %0d, want 3", cntFs); end
    nChecks++; if (codeFs !== RX_ERR_NONE || eFs.size() != 0) begin nFails++; $display("[TB] FAIL basic_no_error: code %0d pulses %0d, want 0 0", codeFs, eFs.size()); end
  endtask

  task automatic test_stuff();
    doReset();
    clearMon();
    txBytes = '{8'h69, 8'hFF, 8'hFF};
    sendPacket(7);
    nChecks++; if (qFs.size() != 3 || qFs[1] !== 8'hFF || qFs[2] !== 8'hFF) begin nFails++; $display("[TB] FAIL stuff_clean_data: got %0d bytes, want 69 FF FF", qFs.size()); end
    nChecks++; if (eFs.size() != 0) begin nFails++; $display("[TB] FAIL stuff_clean_err: got %0d pulses, want 0", eFs.size()); end
    txIdle(3);
    clearMon();
    txSync(7);
    txByte(8'h69);
    repeat (7) txRaw(1'b1);
    repeat (3) applyStimulus(1'b0, txLine, 1'b0);
    nChecks++; if (eFs.size() != 1 || eFs[0] !== RX_ERR_STUFF) begin nFails++; $display("[TB] FAIL stuff_violation_pulse: got %0d pulses, want 1 STUFF", eFs.size()); end
    nChecks++; if (codeFs !== RX_ERR_STUFF) begin nFails++; $display("[TB] FAIL stuff_err_code: got %0d, want 1", codeFs); end
    nChecks++; if (qFs.size() != 1) begin nFails++; $display("[TB] FAIL stuff_valid_count: got %0d, want 1", qFs.size()); end
    // One J short of the recovery run: the following packet must be ignored
    clearMon();
    txIdle(7);
    txBytes = '{8'hC3};
    sendPacket(7);
    nChecks++; if (qFs.size() != 0 || actFs != 0) begin nFails++; $display("[TB] FAIL abort_holds: got %0d bytes %0d active, want 0 0", qFs.size(), actFs); end
    nChecks++; if (codeFs !== RX_ERR_STUFF) begin nFails++; $display("[TB] FAIL abort_sticky: got %0d, want 1", codeFs); end
    txIdle(8);
    clearMon();
    fillRandom(2);
    sendPacket(7);
    nChecks++; if (qFs.size() != 2 || qFs[0] !== txBytes[0] || qFs[1] !== txBytes[1]) begin nFails++; $display("[TB] FAIL abort_recover: got %0d bytes, want %h %h", qFs.size(), txBytes[0], txBytes[1]); end
    nChecks++; if (codeFs !== RX_ERR_NONE) begin nFails++; $display("[TB] FAIL abort_code_clear: got %0d, want 0", codeFs); end
  endtask

  task automatic test_align();
    logic a0, a1, a2;
    logic [7:0] partial = 8'h5A;
    doReset();
    clearMon();
    txSync(7);
    txByte(8'h69);
    for (int i = 0; i < 3; i++) txData(partial[i]);
    sendEop(a0, a1, a2);
    nChecks++; if ({a0, a1, a2} !== 3'b100) begin nFails++; $display("[TB] FAIL align_active: got %b, want 100", {a0, a1, a2}); end
    nChecks++; if (qFs.size() != 1 || qFs[0] !== 8'h69) begin nFails++; $display("[TB] FAIL align_valid: got %0d bytes, want one 69", qFs.size()); end
    nChecks++; if (eFs.size() != 1 || eFs[0] !== RX_ERR_ALIGN) begin nFails++; $display("[TB] FAIL align_pulse: got %0d pulses, want 1 ALIGN", eFs.size()); end
    txIdle(8);
    nChecks++; if (codeFs !== RX_ERR_ALIGN || cntFs !== 11'd1) begin nFails++; $display("[TB] FAIL align_hold: code %0d cnt %0d, want 2 1", codeFs, cntFs); end
    clearMon();
    fillRandom(3);
    sendPacket(7);
    nChecks++; if (qFs.size() != 3 || qFs[2] !== txBytes[2] || cntFs !== 11'd3) begin nFails++; $display("[TB] FAIL align_recover: got %0d bytes cnt %0d, want 3 3", qFs.size(), cntFs); end
  endtask

  task automatic test_overflow();
    doReset();
    clearMon();
    fillRandom(5);
    txSync(7);
    foreach (txBytes[i]) txByte(txBytes[i]);
    repeat (3) applyStimulus(1'b0, txLine, 1'b0);
    nChecks++; if (qOv.size() != 4) begin nFails++; $display("[TB] FAIL ovfl_valid_count: got %0d, want 4", qOv.size()); end
    else for (int i = 0; i < 4; i++) begin
      nChecks++; if (qOv[i] !== txBytes[i]) begin nFails++; $display("[TB] FAIL ovfl_data[%0d]: got %h, want %h", i, qOv[i], txBytes[i]); end
    end
    nChecks++; if (cntOv !== 11'd4) begin nFails++; $display("[TB] FAIL ovfl_byte_cnt: got %0d, want 4", cntOv); end
    nChecks++; if (eOv.size() != 1 || codeOv !== RX_ERR_OVFL) begin nFails++; $display("[TB] FAIL ovfl_err: pulses %0d code %0d, want 1 3", eOv.size(), codeOv); end
    nChecks++; if (qFs.size() != 5 || eFs.size() != 0) begin nFails++; $display("[TB] FAIL ovfl_default_limit: got %0d bytes %0d errs, want 5 0", qFs.size(), eFs.size()); end
  endtask

  task automatic test_sync_hunt();
    doReset();
    clearMon();
    fillRandom(2);
    sendPacket(29);
    nChecks++; if (qHs.size() != 2 || qHs[0] !== txBytes[0] || qHs[1] !== txBytes[1]) begin nFails++; $display("[TB] FAIL hs_sync_lock: got %0d bytes, want %h %h", qHs.size(), txBytes[0], txBytes[1]); end
    nChecks++; if (eHs.size() != 0) begin nFails++; $display("[TB] FAIL hs_no_error: got %0d pulses, want 0", eHs.size()); end
    txIdle(3);
    clearMon();
    txBytes = '{8'h69, 8'h12};
    sendPacket(5);
    nChecks++; if (qFs.size() != 0 || actFs != 0) begin nFails++; $display("[TB] FAIL short_sync: got %0d bytes %0d active, want 0 0", qFs.size(), actFs); end
  endtask

  task automatic test_back_to_back();
    int len;
    doReset();
    for (int p = 0; p < 5; p++) begin
      clearMon();
      len = $urandom_range(1, 6);
      fillRandom(len);
      sendPacket(7);
      nChecks++; if (qFs.size() != len) begin nFails++; $display("[TB] FAIL b2b_count pkt %0d: got %0d, want %0d", p, qFs.size(), len); end
      else for (int i = 0; i < len; i++) begin
        nChecks++; if (qFs[i] !== txBytes[i]) begin nFails++; $display("[TB] FAIL b2b_data pkt %0d byte %0d: got %h, want %h", p, i, qFs[i], txBytes[i]); end
      end
      nChecks++; if (cntFs !== 11'(len) || eFs.size() != 0) begin nFails++; $display("[TB] FAIL b2b_cnt pkt %0d: cnt %0d errs %0d, want %0d 0", p, cntFs, eFs.size(), len); end
      txIdle($urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v = 8'hA5;
    doReset();
    txSync(7);
    txByte(8'h69);
    for (int i = 0; i < 7; i++) txData(v[i]);
    clearMon();
    if (!v[7]) txLine = ~txLine;
    applyStimulus(1'b1, txLine, 1'b1);
    #3 resetN = 1'b0;
    #1;
    nChecks++; if (dataFs !== 8'h00 || cntFs !== 11'd0) begin nFails++; $display("[TB] FAIL midreset_regs: data %h cnt %0d, want 00 0", dataFs, cntFs); end
    nChecks++; if ({validFs, activeFs, errorFs, codeFs} !== 5'b0) begin nFails++; $display("[TB] FAIL midreset_flags: got %b, want 00000", {validFs, activeFs, errorFs, codeFs}); end
    clkEn = 1'b0; eopIn = 1'b0; dIn = LINE_J;
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;
    txLine = LINE_J;
    txOnes = 0;
    @(negedge clk);
    nChecks++; if (qFs.size() != 0 || eFs.size() != 0) begin nFails++; $display("[TB] FAIL midreset_pulses: valid %0d error %0d, want 0 0", qFs.size(), eFs.size()); end
    clearMon();
    fillRandom(3);
    sendPacket(7);
    nChecks++; if (qFs.size() != 3 || qFs[0] !== txBytes[0] || qFs[2] !== txBytes[2]) begin nFails++; $display("[TB] FAIL midreset_recover: got %0d bytes, want 3", qFs.size()); end
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_basic();
    test_stuff();
    test_align();
    test_overflow();
    test_sync_hunt();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
